csr_commit: RTL and testbench
=============================

// Module: csr_commit
// PURPOSE
//  Writeback-side CSR/exception initiator; drives the CSR register file's csr_we/num/wmask/wdata, excp_flush and ertn_flush.
//  Serializes CSRRD/CSRWR/CSRXCHG/ERTN/SYSCALL/BREAK and tagged exceptions, one op at a time.
//  Returns the old CSR value to the GPR file, issues pipeline flush + redirect PC, then drains younger ops.
// PARAMETERS
//  DRAIN_CYCLES  3  cycles in DRAIN after a flush; 0 = return to IDLE directly
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  in_valid       in   1   op offered
//  in_ready       out  1   op accepted when in_valid&in_ready
//  in_pc          in   32  op PC
//  in_op          in   3   0 NONE,1 CSRRD,2 CSRWR,3 CSRXCHG,4 ERTN,5 SYSCALL,6 BREAK
//  in_csr_num     in   14  CSR index
//  in_rd_val      in   32  write data (CSRWR/CSRXCHG)
//  in_rj_val      in   32  write mask (CSRXCHG)
//  in_excp_vld    in   1   earlier-stage exception tag
//  in_excp_ecode  in   6   its ecode
//  in_excp_esub   in   3   its esubcode
//  csr_we         out  1   CSR write strobe
//  csr_num        out  14  CSR index
//  csr_wmask      out  32  CSR write mask
//  csr_wdata      out  32  CSR write data
//  csr_rdata      in   32  CSR read data (combinational on csr_num)
//  excp_flush     out  1   exception commit strobe
//  ertn_flush     out  1   ertn commit strobe
//  ecode          out  6   exception code
//  esubcode       out  3   exception subcode
//  epc            out  32  faulting PC
//  era            in   32  CSR ERA
//  eentry         in   32  CSR EENTRY
//  has_int        in   1   pending enabled interrupt
//  rf_we          out  1   GPR write strobe
//  rf_wdata       out  32  old CSR value
//  flush_req      out  1   pipeline flush strobe
//  flush_pc       out  32  redirect PC
// BEHAVIOUR
//  - Reset: state IDLE; entry cleared; every output 0 except in_ready=1; DRAIN counter 0. Reset in any state aborts the op, no strobe.
//  - FSM IDLE->COMMIT on accept; COMMIT->DRAIN on exception/ertn (or ->IDLE if DRAIN_CYCLES=0), else ->IDLE; DRAIN->IDLE after DRAIN_CYCLES cycles.
//  - in_ready=1 in IDLE and DRAIN, 0 in COMMIT; max throughput one op per 2 cycles. Ops accepted in DRAIN are discarded, no output.
//  - Accept latches all in_* into a 1-entry register; all outputs driven from it only during the single COMMIT cycle, else 0.
//  - csr_num = entry csr_num in COMMIT for CSR ops; rf_wdata = csr_rdata (pre-write value), rf_we=1 for CSRRD/CSRWR/CSRXCHG.
//  - CSRRD: csr_we=0. CSRWR: csr_we=1, wmask=32'hFFFF_FFFF, wdata=rd_val. CSRXCHG: csr_we=1, wmask=rj_val, wdata=rd_val.
//  - ERTN: ertn_flush=1, flush_req=1, flush_pc=era.
//  - SYSCALL ecode 6'h0B, BREAK 6'h0C, esub 0. Tagged: ecode/esub from entry. Exception COMMIT: excp_flush=1, flush_req=1, epc=entry pc, flush_pc=eentry.
//  - Priority: interrupt (if enabled) > in_excp_vld > SYSCALL/BREAK > ERTN > CSR op. Any exception: csr_we=0, rf_we=0, ertn_flush=0.
//  - in_op NONE without exception: COMMIT cycle with no strobes.
//  - excp_flush, ertn_flush, csr_we mutually exclusive every cycle.
// CONFIGURATION
//  CSR_COMMIT_INT_EN defined: has_int sampled at accept; if 1, entry tagged ecode 6'h00, esub 0, overriding any other op/tag.
//  Undefined: has_int ignored; no interrupt path.
// STRUCTURE
//  myCPU.h: op encodings, ECODE_INT/ADE/SYS/BRK/INE, CSR_* indices, FSM state encodings.
//  Sub-module commit_flush_fsm: state + DRAIN counter, in_ready, flush sequencing; datapath stays in csr_commit.
// TESTING
//  CSRWR num 14'h30, rd_val 32'h1234_5678, rdata 32'hDEAD_BEEF -> COMMIT: csr_we=1, wmask FFFF_FFFF, wdata 12345678, rf_wdata DEADBEEF; in_ready=1 next cycle.
//  CSRXCHG rj_val 32'h0000_00FF, rd_val 32'hA5A5_A5A5 -> csr_wmask 000000FF, csr_wdata A5A5A5A5, rf_we=1.
//  SYSCALL pc 32'h1C00_0100, eentry 32'h1C00_8000 -> excp_flush, ecode 0B, epc 1C000100, flush_pc 1C008000; 3 DRAIN ops dropped silently.
//  CSRWR with in_excp_vld, ecode 6'h08 -> csr_we=0, rf_we=0, excp_flush=1, ecode 08.
//  ERTN, era 32'h1C00_0104 -> ertn_flush=1, flush_pc 1C000104, no excp_flush; reset in DRAIN -> IDLE next cycle, outputs 0.
//  has_int=1 with CSRRD: INT_EN -> excp_flush, ecode 00, rf_we=0; without -> plain CSRRD, rf_we=1.

Source files
------------

// File: rtl/csr_commit_pkg.sv
// Shared definitions for the CSR commit block: op encodings, exception codes,
// CSR indices, FSM states and the latched-op entry layout.
package csr_commit_pkg;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4,
    OP_SYSCALL = 3'd5,
    OP_BREAK   = 3'd6
  } op_e;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_EENTRY = 14'h000C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // One latched op. An accepted interrupt is folded into excp_vld/ecode/esub.
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [13:0] csr_num;
    logic [31:0] rd_val;
    logic [31:0] rj_val;
    logic        excp_vld;
    logic [5:0]  ecode;
    logic [2:0]  esub;
  } entry_t;

  // CSR access ops (read, write, exchange) that return the old value to a GPR.
  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG);
  endfunction

endpackage

// File: rtl/csr_commit_flush_fsm.sv
// Control half of csr_commit: IDLE/COMMIT/DRAIN sequencing, drain counter and
// the in_ready handshake. The datapath lives in the top.
module csr_commit_flush_fsm
  import csr_commit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic flush,      // COMMIT cycle is an exception or ertn
  output logic in_ready,
  output logic accept,     // op latched into the entry this cycle
  output logic commit      // entry is being committed this cycle
);

  localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and drain counter registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: COMMIT lasts exactly one cycle, DRAIN lasts DRAIN_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (flush && (DRAIN_CYCLES != 0)) begin
          state_d = ST_DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q <= CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ops offered during DRAIN are handshaken but never latched.
  assign in_ready = (state_q != ST_COMMIT);
  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign commit   = (state_q == ST_COMMIT);

endmodule

// File: rtl/csr_commit.sv
// Writeback-side CSR/exception initiator. Latches one op, commits it in a
// single cycle (CSR access, ertn or exception), then drains younger ops.
// Optional feature: define CSR_COMMIT_INT_EN to sample has_int at accept and
// turn the op into an interrupt exception.
module csr_commit
  import csr_commit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_op,
  input  logic [13:0] in_csr_num,
  input  logic [31:0] in_rd_val,
  input  logic [31:0] in_rj_val,
  input  logic        in_excp_vld,
  input  logic [5:0]  in_excp_ecode,
  input  logic [2:0]  in_excp_esub,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [5:0]  ecode,
  output logic [2:0]  esubcode,
  output logic [31:0] epc,
  input  logic [31:0] era,
  input  logic [31:0] eentry,
  input  logic        has_int,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        flush_req,
  output logic [31:0] flush_pc
);

  entry_t entry_q, entry_d;
  logic   accept, commit;
  logic   is_excp;

  csr_commit_flush_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .flush    (flush_req),
    .in_ready (in_ready),
    .accept   (accept),
    .commit   (commit)
  );

  // Build the entry from the offered op; a pending interrupt overrides everything.
  always_comb begin
    entry_d          = '0;
    entry_d.pc       = in_pc;
    entry_d.op       = in_op;
    entry_d.csr_num  = in_csr_num;
    entry_d.rd_val   = in_rd_val;
    entry_d.rj_val   = in_rj_val;
    entry_d.excp_vld = in_excp_vld;
    entry_d.ecode    = in_excp_ecode;
    entry_d.esub     = in_excp_esub;
`ifdef CSR_COMMIT_INT_EN
    if (has_int) begin
      entry_d.excp_vld = 1'b1;
      entry_d.ecode    = ECODE_INT;
      entry_d.esub     = 3'd0;
    end
`endif
  end

`ifndef CSR_COMMIT_INT_EN
  logic unused_has_int;
  assign unused_has_int = has_int;
`endif

  // One-entry op register, written only on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
    end else if (accept) begin
      entry_q <= entry_d;
    end
  end

  assign is_excp = entry_q.excp_vld || (entry_q.op == OP_SYSCALL) || (entry_q.op == OP_BREAK);

  // Commit-cycle outputs in priority order: exception > ertn > CSR access.
  always_comb begin
    csr_we     = 1'b0;
    csr_num    = '0;
    csr_wmask  = '0;
    csr_wdata  = '0;
    excp_flush = 1'b0;
    ertn_flush = 1'b0;
    ecode      = '0;
    esubcode   = '0;
    epc        = '0;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    flush_req  = 1'b0;
    flush_pc   = '0;
    if (commit) begin
      if (is_excp) begin
        excp_flush = 1'b1;
        flush_req  = 1'b1;
        epc        = entry_q.pc;
        flush_pc   = eentry;
        if (entry_q.excp_vld) begin
          ecode    = entry_q.ecode;
          esubcode = entry_q.esub;
        end else begin
          ecode    = (entry_q.op == OP_SYSCALL) ? ECODE_SYS : ECODE_BRK;
        end
      end else if (entry_q.op == OP_ERTN) begin
        ertn_flush = 1'b1;
        flush_req  = 1'b1;
        flush_pc   = era;
      end else if (is_csr_op(entry_q.op)) begin
        csr_num  = entry_q.csr_num;
        rf_we    = 1'b1;
        rf_wdata = csr_rdata;
        if (entry_q.op == OP_CSRWR) begin
          csr_we    = 1'b1;
          csr_wmask = 32'hFFFF_FFFF;
          csr_wdata = entry_q.rd_val;
        end else if (entry_q.op == OP_CSRXCHG) begin
          csr_we    = 1'b1;
          csr_wmask = entry_q.rj_val;
          csr_wdata = entry_q.rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_commit.sv
// Self-checking bench for csr_commit: directed cases followed by random
// traffic, compared every cycle against a transaction-level reference model.
// Define CSR_COMMIT_INT_EN for both bench and RTL to cover the interrupt path.
module tb_csr_commit;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [2:0]  in_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_val;
  logic [31:0] in_rj_val;
  logic        in_excp_vld;
  logic [5:0]  in_excp_ecode;
  logic [2:0]  in_excp_esub;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        excp_flush;
  logic        ertn_flush;
  logic [5:0]  ecode;
  logic [2:0]  esubcode;
  logic [31:0] epc;
  logic [31:0] era;
  logic [31:0] eentry;
  logic        has_int;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        flush_req;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_commit #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_csr_num(in_csr_num),
    .in_rd_val(in_rd_val), .in_rj_val(in_rj_val), .in_excp_vld(in_excp_vld),
    .in_excp_ecode(in_excp_ecode), .in_excp_esub(in_excp_esub),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .excp_flush(excp_flush),
    .ertn_flush(ertn_flush), .ecode(ecode), .esubcode(esubcode), .epc(epc),
    .era(era), .eentry(eentry), .has_int(has_int), .rf_we(rf_we),
    .rf_wdata(rf_wdata), .flush_req(flush_req), .flush_pc(flush_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [13:0] num;
    logic [31:0] rd;
    logic [31:0] rj;
    logic        ev;
    logic [5:0]  ec;
    logic [2:0]  es;
    logic        hi;
  } txn_t;

  typedef struct packed {
    logic        in_ready;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  ecode;
    logic [2:0]  esubcode;
    logic [31:0] epc;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        flush_req;
    logic [31:0] flush_pc;
  } exp_t;

  // Model state: an op waiting to commit, and how many drain cycles remain.
  bit   pending = 0;
  int   drain_left = 0;
  txn_t entry;
  exp_t e;

  // Expected outputs for one cycle, straight from the op semantics.
  function automatic exp_t ref_model(input txn_t t, input bit cmt,
                                     input logic [31:0] rdata, input logic [31:0] era_v,
                                     input logic [31:0] eentry_v);
    exp_t r;
    bit   intr;
    r = '0;
    intr = 1'b0;
    r.in_ready = !cmt;
    if (!cmt) return r;
`ifdef CSR_COMMIT_INT_EN
    intr = t.hi;
`endif
    if (intr || t.ev || t.op == 3'd5 || t.op == 3'd6) begin
      r.excp_flush = 1'b1;
      r.flush_req  = 1'b1;
      r.epc        = t.pc;
      r.flush_pc   = eentry_v;
      if (intr)          begin r.ecode = 6'h00; r.esubcode = 3'd0; end
      else if (t.ev)     begin r.ecode = t.ec;  r.esubcode = t.es; end
      else if (t.op == 3'd5) r.ecode = 6'h0B;
      else                   r.ecode = 6'h0C;
    end else if (t.op == 3'd4) begin
      r.ertn_flush = 1'b1;
      r.flush_req  = 1'b1;
      r.flush_pc   = era_v;
    end else if (t.op >= 3'd1 && t.op <= 3'd3) begin
      r.csr_num  = t.num;
      r.rf_we    = 1'b1;
      r.rf_wdata = rdata;
      if (t.op != 3'd1) begin
        r.csr_we    = 1'b1;
        r.csr_wdata = t.rd;
        r.csr_wmask = (t.op == 3'd2) ? 32'hFFFF_FFFF : t.rj;
      end
    end
    return r;
  endfunction

  task automatic offer(input logic [2:0] op, input logic [31:0] pc, input logic [13:0] num,
                       input logic [31:0] rd, input logic [31:0] rj, input logic ev,
                       input logic [5:0] ec, input logic hi);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_csr_num = num; in_rd_val = rd;
    in_rj_val = rj; in_excp_vld = ev; in_excp_ecode = ec; in_excp_esub = 3'd0; has_int = hi;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_op = 3'd0; has_int = 1'b0; in_excp_vld = 1'b0;
  endtask

  // Check this cycle against the model, advance the model past the next edge.
  task automatic step();
    #1;
    e = ref_model(entry, pending, csr_rdata, era, eentry);
    checks++;
    assert (in_ready === e.in_ready) else begin
      errors++; $error("FAIL in_ready obs=%0b exp=%0b", in_ready, e.in_ready);
    end
    checks++;
    assert ({csr_we, csr_num, csr_wmask, csr_wdata} === {e.csr_we, e.csr_num, e.csr_wmask, e.csr_wdata}) else begin
      errors++; $error("FAIL csr_port obs=%b/%h/%h/%h exp=%b/%h/%h/%h", csr_we, csr_num, csr_wmask, csr_wdata,
                       e.csr_we, e.csr_num, e.csr_wmask, e.csr_wdata);
    end
    checks++;
    assert ({excp_flush, ertn_flush, ecode, esubcode, epc} === {e.excp_flush, e.ertn_flush, e.ecode, e.esubcode, e.epc}) else begin
      errors++; $error("FAIL excp_port obs=%b/%b/%h/%h/%h exp=%b/%b/%h/%h/%h", excp_flush, ertn_flush, ecode, esubcode, epc,
                       e.excp_flush, e.ertn_flush, e.ecode, e.esubcode, e.epc);
    end
    checks++;
    assert ({rf_we, rf_wdata} === {e.rf_we, e.rf_wdata}) else begin
      errors++; $error("FAIL rf_port obs=%b/%h exp=%b/%h", rf_we, rf_wdata, e.rf_we, e.rf_wdata);
    end
    checks++;
    assert ({flush_req, flush_pc} === {e.flush_req, e.flush_pc}) else begin
      errors++; $error("FAIL flush_port obs=%b/%h exp=%b/%h", flush_req, flush_pc, e.flush_req, e.flush_pc);
    end
    if (reset) begin
      pending = 0; drain_left = 0;
    end else if (pending) begin
      pending = 0;
      if (e.flush_req) drain_left = DRAIN;
    end else if (drain_left > 0) begin
      drain_left--;
    end else if (in_valid) begin
      pending = 1;
      entry = '{pc: in_pc, op: in_op, num: in_csr_num, rd: in_rd_val, rj: in_rj_val,
                ev: in_excp_vld, ec: in_excp_ecode, es: in_excp_esub, hi: has_int};
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; idle_in();
    in_pc = '0; in_csr_num = '0; in_rd_val = '0; in_rj_val = '0;
    in_excp_ecode = '0; in_excp_esub = '0;
    csr_rdata = '0; era = '0; eentry = '0;
    entry = '{default: '0};
    @(negedge clk); @(negedge clk);
    step();                       // reset state
    reset = 1'b0;
    step();

    // CSRWR: full-mask write, old value returned
    offer(3'd2, 32'h1C00_0000, 14'h30, 32'h1234_5678, 32'h0, 1'b0, 6'h0, 1'b0);
    step();
    idle_in(); csr_rdata = 32'hDEAD_BEEF;
    step();
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL ready_after_csrwr obs=%0b exp=1", in_ready); end
    step();

    // CSRXCHG: masked write
    offer(3'd3, 32'h1C00_0004, 14'h31, 32'hA5A5_A5A5, 32'h0000_00FF, 1'b0, 6'h0, 1'b0);
    step();
    idle_in(); csr_rdata = 32'h0BAD_F00D;
    step();

    // SYSCALL, then three ops offered during DRAIN are dropped
    offer(3'd5, 32'h1C00_0100, 14'h0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0);
    eentry = 32'h1C00_8000;
    step();
    step();
    offer(3'd2, 32'h1C00_0104, 14'h5, 32'h5555_0000, 32'h0, 1'b0, 6'h0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    idle_in();
    step();

    // CSRWR tagged with an earlier exception
    offer(3'd2, 32'h1C00_0200, 14'h30, 32'h1111_2222, 32'h0, 1'b1, 6'h08, 1'b0);
    step();
    idle_in();
    step();
    for (int i = 0; i < DRAIN; i++) step();

    // ERTN, then reset during DRAIN
    offer(3'd4, 32'h1C00_0300, 14'h0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0);
    era = 32'h1C00_0104;
    step();
    idle_in();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    offer(3'd0, 32'h1C00_0400, 14'h0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0);
    step();                       // accepted immediately: drain was aborted
    idle_in();
    step();

    // CSRRD with a pending interrupt
    offer(3'd1, 32'h1C00_0500, 14'h6, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1);
    step();
    idle_in(); csr_rdata = 32'h7777_8888;
    step();
    for (int i = 0; i < DRAIN; i++) step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid      = ($urandom_range(0, 9) < 7);
      in_op         = 3'($urandom_range(0, 7));
      in_pc         = $urandom;
      in_csr_num    = 14'($urandom);
      in_rd_val     = $urandom;
      in_rj_val     = $urandom;
      in_excp_vld   = ($urandom_range(0, 9) < 2);
      in_excp_ecode = 6'($urandom);
      in_excp_esub  = 3'($urandom);
      has_int       = ($urandom_range(0, 9) < 2);
      csr_rdata     = $urandom;
      era           = $urandom;
      eentry        = $urandom;
      reset         = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; idle_in();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
